// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: request ops, RV32 funct3
// codes, FSM states and the store lane/alignment helpers.
package dm_lsu_pkg;

    localparam logic [1:0] LSU_OP_NONE   = 2'b00;
    localparam logic [1:0] LSU_OP_LOAD   = 2'b01;
    localparam logic [1:0] LSU_OP_STORE  = 2'b10;
    localparam logic [1:0] LSU_OP_FENCEI = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE        = 2'b00;
    localparam logic [1:0] ST_LOAD_DATA   = 2'b01;
    localparam logic [1:0] ST_FENCE_ISSUE = 2'b10;
    localparam logic [1:0] ST_FENCE_WAIT  = 2'b11;

    typedef struct packed {
        logic [3:0]  ben;
        logic [31:0] wdata;
    } lsu_store_lanes_t;

    // Unsupported funct3 codes are folded into the same error path as misalignment.
    function automatic logic lsu_access_bad(input logic is_store, input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lo[0];
            F3_W:    bad = |lo;
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic lsu_store_lanes_t lsu_store_lanes(input logic [2:0] f3,
                                                         input logic [1:0] lane,
                                                         input logic [31:0] wdata);
        lsu_store_lanes_t r;
        case (f3)
            F3_B: begin
                r.ben   = 4'b0001 << lane;
                r.wdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                r.ben   = lane[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{wdata[15:0]}};
            end
            default: begin
                r.ben   = 4'b1111;
                r.wdata = wdata;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Combinational load-data lane extraction with sign/zero extension.
module dm_load_align
    import dm_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] shifted;

    assign shifted  = i_rdata >> {i_lane, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   o_data = {24'h0, byte_sel};
            F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   o_data = {16'h0, half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/dm_load_store_unit.sv
// Requester side of the main_mem data port: load/store/fence.i sequencing.
// Optional macro DM_LSU_RANGE_CHECK_EN rejects addresses beyond the DM window.
module dm_load_store_unit
    import dm_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DM_AW  = 14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_dm_ren,
    output logic              o_dm_wen,
    output logic [3:0]        o_dm_ben,
    output logic [DM_AW-1:0]  o_dm_addr,
    output logic [31:0]       o_dm_wdata,
    output logic              o_fence_i,
    input  logic [31:0]       i_dm_rdata,
    input  logic              i_mem_ready,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err
);
    logic [1:0] state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic [2:0] f3_q, f3_d;
    logic       resp_q, resp_d;
    logic       err_q, err_d;

    logic accept, is_load, is_store, is_fence, is_mem, bad, range_bad, mem_ok, fence_done;
    lsu_store_lanes_t st_lanes;
    logic [31:0]      load_data;

    // Gating with i_rst_n keeps every strobe low for the whole reset window.
    assign o_req_ready = i_rst_n && (state_q == ST_IDLE) && i_mem_ready;
    assign accept      = i_req_valid && o_req_ready;
    assign is_load     = (i_req_op == LSU_OP_LOAD);
    assign is_store    = (i_req_op == LSU_OP_STORE);
    assign is_fence    = (i_req_op == LSU_OP_FENCEI);
    assign is_mem      = is_load || is_store;

`ifdef DM_LSU_RANGE_CHECK_EN
    assign range_bad = |i_addr[ADDR_W-1:DM_AW+2];
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^i_addr[ADDR_W-1:DM_AW+2];
    assign range_bad      = 1'b0;
`endif

    assign bad      = lsu_access_bad(is_store, i_funct3, i_addr[1:0]) || range_bad;
    assign mem_ok   = accept && is_mem && !bad;
    assign st_lanes = lsu_store_lanes(i_funct3, i_addr[1:0], i_wdata);

    assign o_dm_ren   = mem_ok && is_load;
    assign o_dm_wen   = mem_ok && is_store;
    assign o_dm_ben   = o_dm_wen ? st_lanes.ben : 4'b0000;
    assign o_dm_wdata = o_dm_wen ? st_lanes.wdata : 32'h0;
    assign o_dm_addr  = mem_ok ? i_addr[DM_AW+1:2] : '0;
    assign o_fence_i  = accept && is_fence;

    dm_load_align u_align (
        .i_rdata  (i_dm_rdata),
        .i_lane   (lane_q),
        .i_funct3 (f3_q),
        .o_data   (load_data)
    );

    assign fence_done   = (state_q == ST_FENCE_WAIT) && i_mem_ready;
    assign o_resp_valid = resp_q || (state_q == ST_LOAD_DATA) || fence_done;
    assign o_resp_rdata = (state_q == ST_LOAD_DATA) ? load_data : 32'h0;
    assign o_resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        f3_d    = f3_q;
        resp_d  = accept && is_mem && (is_store || bad);
        err_d   = accept && is_mem && bad;
        case (state_q)
            ST_IDLE: begin
                if (mem_ok && is_load) begin
                    state_d = ST_LOAD_DATA;
                    lane_d  = i_addr[1:0];
                    f3_d    = i_funct3;
                end else if (accept && is_fence) begin
                    state_d = ST_FENCE_ISSUE;
                end
            end
            ST_LOAD_DATA:   state_d = ST_IDLE;
            // The memory only drops ready one cycle after the pulse, so skip a cycle first.
            ST_FENCE_ISSUE: state_d = ST_FENCE_WAIT;
            ST_FENCE_WAIT: begin
                if (i_mem_ready) state_d = ST_IDLE;
            end
            default:        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'b00;
            f3_q    <= 3'b000;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            f3_q    <= f3_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Self-checking bench for dm_load_store_unit: directed table, corner sequences, random vs model.
module tb_dm_load_store_unit;
    import dm_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        dm_ren, dm_wen, fence_i;
    logic [3:0]  dm_ben;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = 32'h0;
    logic        mem_ready = 1'b1;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_load_store_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_dm_ren(dm_ren), .o_dm_wen(dm_wen), .o_dm_ben(dm_ben), .o_dm_addr(dm_addr),
        .o_dm_wdata(dm_wdata), .o_fence_i(fence_i), .i_dm_rdata(dm_rdata),
        .i_mem_ready(mem_ready), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
        .o_resp_err(resp_err)
    );

    // Word-addressed memory on the DM port; rdata holds garbage when not read.
    logic [31:0] bus_mem [0:16383];
    logic        clr_mem = 1'b1;
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 16384; i++) bus_mem[i] <= 32'h0;
        end else begin
            if (dm_ren) dm_rdata <= bus_mem[dm_addr];
            else        dm_rdata <= $urandom;
            if (dm_wen)
                for (int b = 0; b < 4; b++)
                    if (dm_ben[b]) bus_mem[dm_addr][b*8 +: 8] <= dm_wdata[b*8 +: 8];
        end
    end

    // Byte-addressed reference memory for the random phase.
    logic [7:0] ref_mem [0:65535];

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_ben;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [0:18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                          input logic [3:0] exp_ben, input logic [31:0] exp_wd, input string tag);
        int waitc;
        logic is_mem;
        is_mem = (op == LSU_OP_LOAD) || (op == LSU_OP_STORE);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        check({tag, "_ren"}, 32'(dm_ren), 32'((op == LSU_OP_LOAD) && !exp_err));
        check({tag, "_wen"}, 32'(dm_wen), 32'((op == LSU_OP_STORE) && !exp_err));
        check({tag, "_fence"}, 32'(fence_i), 32'd0);
        if (is_mem && !exp_err) check({tag, "_dmaddr"}, 32'(dm_addr), 32'(a[15:2]));
        if (op == LSU_OP_STORE && !exp_err) begin
            check({tag, "_ben"}, 32'(dm_ben), 32'(exp_ben));
            check({tag, "_wdata"}, dm_wdata, exp_wd);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = LSU_OP_NONE;
        @(negedge clk);
        if (!is_mem) begin
            check({tag, "_noresp"}, 32'(resp_valid), 32'd0);
        end else begin
            check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
            check({tag, "_rerr"}, 32'(resp_err), 32'(exp_err));
            check({tag, "_rdata"}, resp_rdata, exp_rd);
            if (op == LSU_OP_LOAD && !exp_err) check({tag, "_busy"}, 32'(req_ready), 32'd0);
        end
        $display("txn %s op=%0d f3=%0d addr=%h err=%0d rdata=%h", tag, op, f3, a, resp_err, resp_rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  r_op;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_wd, r_rd, r_wexp, val;
        logic [3:0]  r_ben;
        logic [15:0] ea;
        logic        r_err, supported;
        int          sz;
        int          pulses;

        tbl[0]  = '{LSU_OP_STORE, F3_W,   32'h104, 32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF};
        tbl[1]  = '{LSU_OP_STORE, F3_B,   32'h103, 32'h000000A5, 1'b0, 32'h0,        4'h8, 32'hA5A5A5A5};
        tbl[2]  = '{LSU_OP_LOAD,  F3_B,   32'h103, 32'h0,        1'b0, 32'hFFFFFFA5, 4'h0, 32'h0};
        tbl[3]  = '{LSU_OP_LOAD,  F3_BU,  32'h103, 32'h0,        1'b0, 32'h000000A5, 4'h0, 32'h0};
        tbl[4]  = '{LSU_OP_STORE, F3_W,   32'h100, 32'h80010000, 1'b0, 32'h0,        4'hF, 32'h80010000};
        tbl[5]  = '{LSU_OP_LOAD,  F3_H,   32'h102, 32'h0,        1'b0, 32'hFFFF8001, 4'h0, 32'h0};
        tbl[6]  = '{LSU_OP_LOAD,  F3_W,   32'h102, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[7]  = '{LSU_OP_LOAD,  F3_HU,  32'h102, 32'h0,        1'b0, 32'h00008001, 4'h0, 32'h0};
        tbl[8]  = '{LSU_OP_LOAD,  F3_W,   32'h104, 32'h0,        1'b0, 32'hDEADBEEF, 4'h0, 32'h0};
        tbl[9]  = '{LSU_OP_STORE, F3_H,   32'h106, 32'h00001234, 1'b0, 32'h0,        4'hC, 32'h12341234};
        tbl[10] = '{LSU_OP_LOAD,  F3_W,   32'h104, 32'h0,        1'b0, 32'h1234BEEF, 4'h0, 32'h0};
        tbl[11] = '{LSU_OP_LOAD,  3'b011, 32'h100, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[12] = '{LSU_OP_STORE, 3'b011, 32'h100, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[13] = '{LSU_OP_STORE, F3_H,   32'h101, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[14] = '{LSU_OP_LOAD,  F3_HU,  32'h105, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        tbl[15] = '{LSU_OP_STORE, F3_B,   32'h100, 32'h000001FF, 1'b0, 32'h0,        4'h1, 32'hFFFFFFFF};
        tbl[16] = '{LSU_OP_LOAD,  F3_W,   32'h100, 32'h0,        1'b0, 32'h800100FF, 4'h0, 32'h0};
        tbl[17] = '{LSU_OP_LOAD,  F3_B,   32'h104, 32'h0,        1'b0, 32'hFFFFFFEF, 4'h0, 32'h0};
        tbl[18] = '{LSU_OP_NONE,  F3_W,   32'h104, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0};

        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        // Reset: a pending load must not leak strobes while reset is held.
        req_valid = 1'b1; req_op = LSU_OP_LOAD; funct3 = F3_W; addr = 32'h104;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ren", 32'(dm_ren), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_fence", 32'(fence_i), 32'd0);
        req_valid = 1'b0; req_op = LSU_OP_NONE;
        repeat (3) @(negedge clk);
        clr_mem = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            do_req(tbl[i].op, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err,
                   tbl[i].exp_rdata, tbl[i].exp_ben, tbl[i].exp_wdata, $sformatf("tbl%0d", i));

        // Memory not ready: the store must wait without strobes.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        req_valid = 1'b1; req_op = LSU_OP_STORE; funct3 = F3_W; addr = 32'h20; wdata = 32'h0BADF00D;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("nr_ready", 32'(req_ready), 32'd0);
            check("nr_wen", 32'(dm_wen), 32'd0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("nr_issue_wen", 32'(dm_wen), 32'd1);
        check("nr_issue_addr", 32'(dm_addr), 32'h8);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = LSU_OP_NONE;
        @(negedge clk);
        check("nr_resp", 32'(resp_valid), 32'd1);
        $display("txn mem_not_ready store done");

        // Fence.i with ready held low for 10 cycles and a store queued behind it.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = LSU_OP_FENCEI;
        @(negedge clk);
        check("fence_accept_ready", 32'(req_ready), 32'd1);
        check("fence_pulse", 32'(fence_i), 32'd1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        req_op = LSU_OP_STORE; funct3 = F3_W; addr = 32'h30; wdata = 32'h12345678;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fence_i) pulses++;
            check("fence_wait_ready", 32'(req_ready), 32'd0);
            check("fence_wait_wen", 32'(dm_wen), 32'd0);
            check("fence_wait_resp", 32'(resp_valid), 32'd0);
        end
        check("fence_extra_pulses", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("fence_done_resp", 32'(resp_valid), 32'd1);
        check("fence_done_err", 32'(resp_err), 32'd0);
        check("fence_done_wen", 32'(dm_wen), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fence_next_wen", 32'(dm_wen), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = LSU_OP_NONE;
        @(negedge clk);
        check("fence_next_resp", 32'(resp_valid), 32'd1);
        $display("txn fence.i sequence done");

        // Upper address bits: rejected with range check, otherwise wrap onto word 0.
`ifdef DM_LSU_RANGE_CHECK_EN
        do_req(LSU_OP_LOAD, F3_W, 32'h0001_0000, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, "range_lw");
`else
        do_req(LSU_OP_LOAD, F3_W, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, "range_lw");
`endif

        // Random loads/stores against the byte-addressed reference model.
        for (int n = 0; n < 300; n++) begin
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = 32'h800 + $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) r_a = r_a | (32'h0001_0000 << $urandom_range(0, 15));
            r_wd = $urandom;
            case ($urandom_range(0, 9))
                0:       r_op = LSU_OP_NONE;
                1, 2, 3, 4: r_op = LSU_OP_STORE;
                default: r_op = LSU_OP_LOAD;
            endcase
            ea = r_a[15:0];
            sz = (r_f3[1:0] == 2'd0) ? 1 : (r_f3[1:0] == 2'd1) ? 2 : 4;
            if (r_op == LSU_OP_LOAD) supported = (r_f3 != 3'd3) && (r_f3 < 3'd6);
            else                     supported = (r_f3 < 3'd3);
            r_err = !supported || ((int'(ea) % sz) != 0);
`ifdef DM_LSU_RANGE_CHECK_EN
            if ((r_a >> 16) != 0) r_err = 1'b1;
`endif
            if (r_op == LSU_OP_NONE) r_err = 1'b0;
            r_rd = 32'h0; r_ben = 4'h0; r_wexp = 32'h0;
            if (r_op == LSU_OP_STORE && !r_err) begin
                r_ben  = 4'(((1 << sz) - 1) << ea[1:0]);
                r_wexp = (sz == 1) ? {4{r_wd[7:0]}} : (sz == 2) ? {2{r_wd[15:0]}} : r_wd;
                for (int b = 0; b < sz; b++) ref_mem[ea + 16'(b)] = 8'(r_wd >> (8 * b));
            end
            if (r_op == LSU_OP_LOAD && !r_err) begin
                val = 32'h0;
                for (int b = 0; b < sz; b++) val = val | (32'(ref_mem[ea + 16'(b)]) << (8 * b));
                if (!r_f3[2] && sz < 4 && val[8*sz-1])
                    val = val | ~((32'd1 << (8 * sz)) - 32'd1);
                r_rd = val;
            end
            do_req(r_op, r_f3, r_a, r_wd, r_err, r_rd, r_ben, r_wexp, $sformatf("rnd%0d", n));
        end

        // Reset asserted while a load sits in LOAD_DATA: response must vanish at once.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = LSU_OP_LOAD; funct3 = F3_W; addr = 32'h104;
        @(negedge clk);
        check("rstmid_ren", 32'(dm_ren), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = LSU_OP_NONE;
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid_resp_rdata", resp_rdata, 32'h0);
        check("rstmid_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstmid_no_resp", 32'(resp_valid), 32'd0);
        end
        $display("txn reset mid-load done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
